// File: rtl/pwm_deadtime_gate_if.sv
// Gate-drive bundle between a PWM command source / dead-time counter and the
// dead-time gate FSM.
interface pwm_deadtime_gate_if;
    logic        Enable;
    logic        PWM_IN;
    logic        Fault;
    logic        FaultClr;
    logic [15:0] PWM_DEAD_TIME;
    logic [15:0] DeadTimeCount;
    logic        isCount;
    logic        PWM_H;
    logic        PWM_L;
    logic        InDead;
    logic        FaultLatched;

    modport master (
        output Enable, PWM_IN, Fault, FaultClr, PWM_DEAD_TIME, DeadTimeCount,
        input  isCount, PWM_H, PWM_L, InDead, FaultLatched
    );

    modport slave (
        input  Enable, PWM_IN, Fault, FaultClr, PWM_DEAD_TIME, DeadTimeCount,
        output isCount, PWM_H, PWM_L, InDead, FaultLatched
    );
endinterface

// File: rtl/pwm_deadtime_gate.sv
// Half-bridge gate driver: synchronizes the raw PWM command and inserts a
// dead band (timed by an external counter) between high- and low-side drive.
module pwm_deadtime_gate (
    input  logic                 clk_100,
    input  logic                 RST,
    pwm_deadtime_gate_if.slave   gate
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DEAD  = 3'd1;
    localparam logic [2:0] ST_H_ON  = 3'd2;
    localparam logic [2:0] ST_L_ON  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    logic       pwm_meta_r;
    logic       pwm_s_r;
    logic [2:0] state_r;
    logic [2:0] state_next_s;
    logic       dead_done_s;
    logic       pwm_h_r;
    logic       pwm_l_r;
    logic       dead_r;
    logic       fault_r;

    assign dead_done_s = (gate.DeadTimeCount == gate.PWM_DEAD_TIME);

    // Two-flop synchronizer for the asynchronous PWM command
    always_ff @(posedge clk_100) begin
        if (RST) begin
            pwm_meta_r <= 1'b0;
            pwm_s_r    <= 1'b0;
        end else begin
            pwm_meta_r <= gate.PWM_IN;
            pwm_s_r    <= pwm_meta_r;
        end
    end

    // Next-state logic: Fault beats Enable, Enable beats normal sequencing
    always_comb begin
        state_next_s = state_r;
        if (gate.Fault) begin
            state_next_s = ST_FAULT;
        end else if (state_r == ST_FAULT) begin
            if (gate.FaultClr) begin
                state_next_s = ST_IDLE;
            end else begin
                state_next_s = ST_FAULT;
            end
        end else if (!gate.Enable) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_DEAD;
                end
                ST_DEAD: begin
                    // Target side is resolved only on the exit edge
                    if (dead_done_s) begin
                        state_next_s = pwm_s_r ? ST_H_ON : ST_L_ON;
                    end else begin
                        state_next_s = ST_DEAD;
                    end
                end
                ST_H_ON: begin
                    if (!pwm_s_r) begin
                        state_next_s = ST_DEAD;
                    end else begin
                        state_next_s = ST_H_ON;
                    end
                end
                ST_L_ON: begin
                    if (pwm_s_r) begin
                        state_next_s = ST_DEAD;
                    end else begin
                        state_next_s = ST_L_ON;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register with outputs registered from the next state, so each
    // output flop always equals a decode of state_r
    always_ff @(posedge clk_100) begin
        if (RST) begin
            state_r <= ST_IDLE;
            pwm_h_r <= 1'b0;
            pwm_l_r <= 1'b0;
            dead_r  <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pwm_h_r <= (state_next_s == ST_H_ON);
            pwm_l_r <= (state_next_s == ST_L_ON);
            dead_r  <= (state_next_s == ST_DEAD);
            fault_r <= (state_next_s == ST_FAULT);
        end
    end

    assign gate.PWM_H        = pwm_h_r;
    assign gate.PWM_L        = pwm_l_r;
    assign gate.isCount      = dead_r;
    assign gate.InDead       = dead_r;
    assign gate.FaultLatched = fault_r;

endmodule
